ext_mem_model_nch: RTL and testbench

- Parametrised external-memory responder for Bambu-generated `main` cores, used in simulation benches.
- Serves N_CH independent master channels against one byte-addressed array.
- Per-channel read and write latencies are programmable; writes are size-masked.
- Adds three things the fixed 2-channel model lacks: a byte preload port, deterministic same-byte conflict resolution, and a sticky protocol-error report.

---
 rtl/ext_mem_pkg.sv | 27 ++
 rtl/ext_mem_channel.sv | 63 ++++++
 rtl/ext_mem_model_nch.sv | 127 ++++++++++++
 tb/tb_ext_mem_model_nch.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_mem_pkg.sv
// Shared helpers for the external-memory responder: access-size masks,
// address range test and the error-channel code used for preload faults.
package ext_mem_pkg;

  localparam int MAX_BYTES = 64;
  localparam logic [31:0] ERR_CH_LOAD = '1;

  // One bit per byte lane that the access touches; lanes past size/8 stay clear.
  function automatic logic [MAX_BYTES-1:0] size_to_bytemask(input logic [31:0] size_bits);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (32'(i) < (size_bits >> 3)) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] nbytes,
                                    input logic [31:0] base, input logic [31:0] depth);
    logic [33:0] last;
    logic [33:0] lim;
    last = {2'b00, addr} + {2'b00, nbytes} - 34'd1;
    lim  = {2'b00, base} + {2'b00, depth};
    return (addr >= base) && (nbytes != 32'd0) && (last < lim);
  endfunction

endpackage

// File: rtl/ext_mem_channel.sv
// One master channel: latency counter, read-data delay register, ready pulse
// and the oe/we collision flag.
module ext_mem_channel import ext_mem_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_oe,
  input  logic              i_we,
  input  logic              i_in_range,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_rdy,
  output logic              o_wr_commit,
  output logic              o_err,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic w_rd_req;
  logic w_wr_req;
  logic w_rd_done;
  logic w_wr_done;

  assign w_rd_req  = i_oe & ~i_we & i_in_range & ~reset;
  assign w_wr_req  = i_we & ~i_oe & i_in_range & ~reset;
  assign w_rd_done = w_rd_req && (r_cnt == CNT_W'(RD_LAT - 1));
  assign w_wr_done = w_wr_req && (r_cnt == CNT_W'(WR_LAT - 1));

  assign o_rdy       = w_rd_done | w_wr_done;
  assign o_wr_commit = w_wr_done;
  assign o_err       = i_oe & i_we;

  // A completed access restarts the count so a held request runs back-to-back.
  always_ff @(posedge clock) begin
    if (reset || !(w_rd_req || w_wr_req) || w_rd_done || w_wr_done) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  generate
    if (RD_LAT == 1) begin : g_rd_comb
      assign o_rdata = w_rd_done ? i_mem_data : '0;
    end else begin : g_rd_pipe
      logic [DATA_W-1:0] r_rdata;
      always_ff @(posedge clock) begin
        if (reset) begin
          r_rdata <= '0;
        end else if (w_rd_req && (r_cnt == CNT_W'(RD_LAT - 2))) begin
          r_rdata <= i_mem_data;
        end
      end
      assign o_rdata = w_rd_done ? r_rdata : '0;
    end
  endgenerate

endmodule

// File: rtl/ext_mem_model_nch.sv
// N-channel byte-addressed memory responder with preload port, fixed write
// priority (higher channel, then preload) and a sticky protocol-error report.
module ext_mem_model_nch import ext_mem_pkg::*; #(
  parameter int N_CH      = 2,
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int SIZE_W    = 6,
  parameter int MEM_BYTES = 4096,
  parameter int BASE_ADDR = 0,
  parameter int RD_LAT    = 2,
  parameter int WR_LAT    = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_CH-1:0]          Mout_oe_ram,
  input  logic [N_CH-1:0]          Mout_we_ram,
  input  logic [N_CH*ADDR_W-1:0]   Mout_addr_ram,
  input  logic [N_CH*DATA_W-1:0]   Mout_Wdata_ram,
  input  logic [N_CH*SIZE_W-1:0]   Mout_data_ram_size,
  input  logic [N_CH*DATA_W-1:0]   Sout_Rdata_ram,
  input  logic [N_CH-1:0]          Sout_DataRdy,
  input  logic                     load_en,
  input  logic [ADDR_W-1:0]        load_addr,
  input  logic [7:0]               load_data,
  output logic [N_CH*DATA_W-1:0]   M_Rdata_ram,
  output logic [N_CH-1:0]          M_DataRdy,
  output logic                     err,
  output logic [$clog2(N_CH):0]    err_ch
);

  localparam int NB    = DATA_W / 8;
  localparam int ERR_W = $clog2(N_CH) + 1;
  localparam int IDX_W = $clog2(MEM_BYTES);

  logic [7:0]             r_mem [MEM_BYTES];
  logic                   r_err;
  logic [ERR_W-1:0]       r_err_ch;

  logic [N_CH-1:0]        w_rdy;
  logic [N_CH-1:0]        w_commit;
  logic [N_CH-1:0]        w_chan_err;
  logic [N_CH-1:0]        w_in_range;
  logic [N_CH*DATA_W-1:0] w_rdata;
  logic [IDX_W-1:0]       w_idx [N_CH];
  logic [NB-1:0]          w_mask [N_CH];
  logic                   w_load_ok;
  logic                   w_load_err;
  logic [IDX_W-1:0]       w_load_idx;
  logic [ERR_W-1:0]       w_first_ch;

  genvar gi, gb;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [ADDR_W-1:0] w_addr;
      logic [SIZE_W-1:0] w_size;
      logic [DATA_W-1:0] w_mem_data;

      assign w_addr         = Mout_addr_ram[gi*ADDR_W +: ADDR_W];
      assign w_size         = Mout_data_ram_size[gi*SIZE_W +: SIZE_W];
      assign w_mask[gi]     = NB'(size_to_bytemask(32'(w_size)));
      assign w_in_range[gi] = in_range(32'(w_addr), 32'(w_size >> 3), 32'(BASE_ADDR), 32'(MEM_BYTES));
      assign w_idx[gi]      = IDX_W'(32'(w_addr) - 32'(BASE_ADDR));

      for (gb = 0; gb < NB; gb++) begin : g_byte
        assign w_mem_data[gb*8 +: 8] = w_mask[gi][gb] ? r_mem[w_idx[gi] + IDX_W'(gb)] : 8'h00;
      end

      ext_mem_channel #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT),
        .WR_LAT (WR_LAT)
      ) u_chan (
        .clock       (clock),
        .reset       (reset),
        .i_oe        (Mout_oe_ram[gi]),
        .i_we        (Mout_we_ram[gi]),
        .i_in_range  (w_in_range[gi]),
        .i_mem_data  (w_mem_data),
        .o_rdy       (w_rdy[gi]),
        .o_wr_commit (w_commit[gi]),
        .o_err       (w_chan_err[gi]),
        .o_rdata     (w_rdata[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

  assign w_load_ok  = load_en && in_range(32'(load_addr), 32'd1, 32'(BASE_ADDR), 32'(MEM_BYTES));
  assign w_load_err = load_en && !w_load_ok;
  assign w_load_idx = IDX_W'(32'(load_addr) - 32'(BASE_ADDR));

  // Later non-blocking writes win: ascending channel order, preload last.
  always_ff @(posedge clock) begin
    for (int c = 0; c < N_CH; c++) begin
      for (int b = 0; b < NB; b++) begin
        if (w_commit[c] && w_mask[c][b]) begin
          r_mem[w_idx[c] + IDX_W'(b)] <= Mout_Wdata_ram[c*DATA_W + b*8 +: 8];
        end
      end
    end
    if (w_load_ok) begin
      r_mem[w_load_idx] <= load_data;
    end
  end

  always_comb begin
    w_first_ch = ERR_CH_LOAD[ERR_W-1:0];
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (w_chan_err[c]) w_first_ch = ERR_W'(c);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_err    <= 1'b0;
      r_err_ch <= '0;
    end else if (!r_err && ((|w_chan_err) || w_load_err)) begin
      r_err    <= 1'b1;
      r_err_ch <= w_first_ch;
    end
  end

  assign M_DataRdy   = w_rdy | Sout_DataRdy;
  assign M_Rdata_ram = w_rdata | Sout_Rdata_ram;
  assign err         = r_err;
  assign err_ch      = r_err_ch;

endmodule

// File: tb/tb_ext_mem_model_nch.sv
// Bench for ext_mem_model_nch: table-driven reads, hand-written corner
// sequences and randomized dual-channel traffic against a byte-array model.
module tb_ext_mem_model_nch;

  localparam int RD_LAT = 2;
  localparam int WR_LAT = 1;

  logic        clock;
  logic        reset;
  logic [1:0]  oe, we;
  logic [25:0] addr;
  logic [63:0] wdata;
  logic [11:0] size;
  logic [63:0] sout_rdata;
  logic [1:0]  sout_rdy;
  logic        load_en;
  logic [12:0] load_addr;
  logic [7:0]  load_data;
  logic [63:0] m_rdata, m3_rdata;
  logic [1:0]  m_rdy, m3_rdy;
  logic        err, err3;
  logic [1:0]  err_ch, err_ch3;

  ext_mem_model_nch dut (
    .clock(clock), .reset(reset), .Mout_oe_ram(oe), .Mout_we_ram(we),
    .Mout_addr_ram(addr), .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
    .Sout_Rdata_ram(sout_rdata), .Sout_DataRdy(sout_rdy), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .M_Rdata_ram(m_rdata),
    .M_DataRdy(m_rdy), .err(err), .err_ch(err_ch)
  );

  ext_mem_model_nch #(.RD_LAT(3)) dut3 (
    .clock(clock), .reset(reset), .Mout_oe_ram(oe), .Mout_we_ram(we),
    .Mout_addr_ram(addr), .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
    .Sout_Rdata_ram(sout_rdata), .Sout_DataRdy(sout_rdy), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .M_Rdata_ram(m3_rdata),
    .M_DataRdy(m3_rdy), .err(err3), .err_ch(err_ch3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] m_mem [4096];

  // per-transaction description: op 0 idle, 1 read, 2 write, 3 oe+we
  int          t_op   [2];
  logic [12:0] t_addr [2];
  logic [5:0]  t_size [2];
  logic [31:0] t_wdata[2];
  int          t_cyc  [2];
  logic        t_pass [2];
  logic        t_srdy [2];
  logic [31:0] t_sdata[2];
  logic [31:0] t_exp  [2];

  typedef struct {
    int          ch;
    logic [12:0] addr;
    logic [5:0]  size;
    logic        pass;
    logic        srdy;
    logic [31:0] sdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] model_read(input int a, input int sz);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < sz / 8; b++) r = r | (32'(m_mem[a + b]) << (8 * b));
    return r;
  endfunction

  task automatic model_write(input int a, input int sz, input logic [31:0] d);
    for (int b = 0; b < sz / 8; b++) m_mem[a + b] = d[8*b +: 8];
  endtask

  // Called at the drive point (just after a rising edge); returns at one.
  task automatic load_byte(input logic [12:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    m_mem[a] = d;
    @(posedge clock); #1;
    load_en = 1'b0;
  endtask

  task automatic set_idle();
    for (int c = 0; c < 2; c++) begin
      t_op[c] = 0; t_addr[c] = '0; t_size[c] = 6'd32; t_wdata[c] = '0;
      t_cyc[c] = 0; t_pass[c] = 1'b0; t_srdy[c] = 1'b0; t_sdata[c] = '0; t_exp[c] = '0;
    end
  endtask

  task automatic run_txn(input string tag);
    $display("txn %s: ch0 op=%0d addr=%0h size=%0d | ch1 op=%0d addr=%0h size=%0d",
             tag, t_op[0], t_addr[0], t_size[0], t_op[1], t_addr[1], t_size[1]);
    for (int c = 0; c < 2; c++) begin
      oe[c] = (t_op[c] == 1) || (t_op[c] == 3);
      we[c] = (t_op[c] == 2) || (t_op[c] == 3);
      addr[c*13 +: 13]       = t_addr[c];
      size[c*6 +: 6]         = t_size[c];
      wdata[c*32 +: 32]      = t_wdata[c];
      sout_rdy[c]            = t_srdy[c];
      sout_rdata[c*32 +: 32] = t_sdata[c];
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      for (int c = 0; c < 2; c++) begin
        if (t_op[c] == 0) begin
          chk($sformatf("%s idle rdy ch%0d c%0d", tag, c, k), 64'(m_rdy[c]), 64'd0);
        end else if (t_pass[c]) begin
          chk($sformatf("%s pass rdy ch%0d c%0d", tag, c, k), 64'(m_rdy[c]), 64'(t_srdy[c]));
          chk($sformatf("%s pass data ch%0d c%0d", tag, c, k), 64'(m_rdata[c*32 +: 32]), 64'(t_sdata[c]));
        end else begin
          chk($sformatf("%s rdy ch%0d c%0d", tag, c, k), 64'(m_rdy[c]), 64'(k == t_cyc[c]));
          if (k == t_cyc[c] && t_op[c] == 1)
            chk($sformatf("%s rdata ch%0d", tag, c), 64'(m_rdata[c*32 +: 32]), 64'(t_exp[c]));
        end
      end
      @(posedge clock); #1;
      for (int c = 0; c < 2; c++) begin
        if (k == t_cyc[c] || k == 3) begin
          oe[c] = 1'b0; we[c] = 1'b0;
        end
      end
    end
    sout_rdy = '0; sout_rdata = '0;
    for (int c = 0; c < 2; c++) begin
      if (t_op[c] == 2 && !t_pass[c]) model_write(int'(t_addr[c]), int'(t_size[c]), t_wdata[c]);
    end
  endtask

  task automatic read_vec(input string tag, input int ch, input logic [12:0] a,
                          input logic [5:0] sz, input logic [31:0] exp);
    set_idle();
    t_op[ch] = 1; t_addr[ch] = a; t_size[ch] = sz; t_cyc[ch] = RD_LAT; t_exp[ch] = exp;
    run_txn(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    oe = '0; we = '0; addr = '0; wdata = '0; size = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    reset = 1'b1; sout_rdy = 2'b10; sout_rdata = {32'h5A5A_0001, 32'h0};

    vecs[0] = '{0, 13'h010, 6'd32, 1'b0, 1'b0, 32'h0,      32'h4433_2211};
    vecs[1] = '{1, 13'h010, 6'd16, 1'b0, 1'b0, 32'h0,      32'h0000_2211};
    vecs[2] = '{0, 13'h011, 6'd24, 1'b0, 1'b0, 32'h0,      32'h0044_3322};
    vecs[3] = '{1, 13'h013, 6'd8,  1'b0, 1'b0, 32'h0,      32'h0000_0044};
    vecs[4] = '{0, 13'hFFC, 6'd32, 1'b0, 1'b0, 32'h0,      32'hFCF5_EEE7};
    vecs[5] = '{1, 13'hFFE, 6'd16, 1'b0, 1'b0, 32'h0,      32'h0000_FCF5};
    vecs[6] = '{0, 13'hFFE, 6'd32, 1'b1, 1'b1, 32'h1234,   32'h0};
    vecs[7] = '{0, 13'h1000, 6'd32, 1'b1, 1'b1, 32'hCAFE,  32'h0};
    vecs[8] = '{1, 13'h1000, 6'd8, 1'b1, 1'b0, 32'h0,      32'h0};

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset rdy passthrough", 64'(m_rdy), 64'(2'b10));
    chk("reset rdata passthrough", m_rdata, {32'h5A5A_0001, 32'h0});
    chk("reset err", 64'(err), 64'd0);
    chk("reset err_ch", 64'(err_ch), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0; sout_rdy = '0; sout_rdata = '0;

    for (int a = 0; a < 256; a++) begin
      logic [7:0] d;
      d = 8'((a * 7 + 3) & 255);
      if (a >= 16 && a <= 19) d = 8'((a - 15) * 17);
      if (a == 35) d = 8'h00;
      load_byte(13'(a), d);
    end
    for (int a = 4080; a < 4096; a++) load_byte(13'(a), 8'((a * 7 + 3) & 255));

    for (int i = 0; i < 9; i++) begin
      set_idle();
      t_op[vecs[i].ch]    = 1;
      t_addr[vecs[i].ch]  = vecs[i].addr;
      t_size[vecs[i].ch]  = vecs[i].size;
      t_pass[vecs[i].ch]  = vecs[i].pass;
      t_srdy[vecs[i].ch]  = vecs[i].srdy;
      t_sdata[vecs[i].ch] = vecs[i].sdata;
      t_cyc[vecs[i].ch]   = vecs[i].pass ? 0 : RD_LAT;
      t_exp[vecs[i].ch]   = vecs[i].exp;
      run_txn($sformatf("vec%0d", i));
    end

    set_idle();
    t_op[1] = 2; t_addr[1] = 13'h020; t_size[1] = 6'd16; t_wdata[1] = 32'hAABB_CCDD; t_cyc[1] = WR_LAT;
    run_txn("wr16");
    read_vec("wr16 readback", 0, 13'h020, 6'd32, 32'h00F1_CCDD);

    set_idle();
    t_op[0] = 2; t_addr[0] = 13'h030; t_size[0] = 6'd8; t_wdata[0] = 32'h55; t_cyc[0] = WR_LAT;
    t_op[1] = 2; t_addr[1] = 13'h030; t_size[1] = 6'd8; t_wdata[1] = 32'h66; t_cyc[1] = WR_LAT;
    run_txn("same-byte wr");
    read_vec("same-byte readback", 0, 13'h030, 6'd8, 32'h66);

    set_idle();
    t_op[0] = 1; t_addr[0] = 13'h060; t_size[0] = 6'd32; t_cyc[0] = RD_LAT; t_exp[0] = 32'hB8B1_AAA3;
    t_op[1] = 2; t_addr[1] = 13'h060; t_size[1] = 6'd32; t_wdata[1] = 32'hDEAD_BEEF; t_cyc[1] = WR_LAT;
    run_txn("rd vs wr");
    read_vec("rd vs wr readback", 1, 13'h060, 6'd32, 32'hDEAD_BEEF);

    $display("txn load-vs-write: ch0 wr 0x50=77, load 0x50=99");
    oe[0] = 1'b0; we[0] = 1'b1; addr[12:0] = 13'h050; size[5:0] = 6'd8; wdata[31:0] = 32'h77;
    load_en = 1'b1; load_addr = 13'h050; load_data = 8'h99;
    @(negedge clock);
    chk("load-vs-write rdy", 64'(m_rdy[0]), 64'd1);
    @(posedge clock); #1;
    we[0] = 1'b0; load_en = 1'b0;
    m_mem[13'h050] = 8'h99;
    read_vec("load-vs-write readback", 0, 13'h050, 6'd8, 32'h99);

    for (int n = 0; n < 40; n++) begin
      set_idle();
      for (int c = 0; c < 2; c++) begin
        t_op[c]    = int'($urandom_range(0, 2));
        t_addr[c]  = 13'(32'h80 + $urandom_range(0, 12));
        t_size[c]  = 6'(8 * $urandom_range(1, 4));
        t_wdata[c] = $urandom;
        t_cyc[c]   = (t_op[c] == 1) ? RD_LAT : (t_op[c] == 2) ? WR_LAT : 0;
        t_exp[c]   = model_read(int'(t_addr[c]), int'(t_size[c]));
      end
      run_txn($sformatf("rand%0d", n));
    end

    @(negedge clock);
    chk("err clear before violation", 64'(err), 64'd0);
    @(posedge clock); #1;
    set_idle();
    t_op[1] = 3; t_addr[1] = 13'h040;
    run_txn("ch1 oe+we");
    chk("err after ch1 violation", 64'(err), 64'd1);
    chk("err_ch after ch1 violation", 64'(err_ch), 64'd1);
    chk("err3 after ch1 violation", 64'(err3), 64'd1);
    chk("err_ch3 after ch1 violation", 64'(err_ch3), 64'd1);
    set_idle();
    t_op[0] = 3; t_addr[0] = 13'h040;
    run_txn("ch0 oe+we");
    chk("err held", 64'(err), 64'd1);
    chk("err_ch held at first", 64'(err_ch), 64'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("err after reset", 64'(err), 64'd0);
    chk("err_ch after reset", 64'(err_ch), 64'd0);
    @(posedge clock); #1;

    $display("txn load error: load_addr 0x1000");
    load_en = 1'b1; load_addr = 13'h1000; load_data = 8'hEE;
    @(posedge clock); #1;
    load_en = 1'b0;
    @(negedge clock);
    chk("load err", 64'(err), 64'd1);
    chk("load err_ch", 64'(err_ch), 64'(2'b11));
    @(posedge clock); #1;

    $display("txn reset mid-read: ch0 addr 0x10");
    oe[0] = 1'b1; we[0] = 1'b0; addr[12:0] = 13'h010; size[5:0] = 6'd32;
    @(negedge clock);
    chk("midreset c1 rdy", 64'(m_rdy[0]), 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("midreset in-reset rdy", 64'(m_rdy[0]), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("midreset restart c1 rdy", 64'(m_rdy[0]), 64'd0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("midreset restart c2 rdy", 64'(m_rdy[0]), 64'd1);
    chk("midreset restart data", 64'(m_rdata[31:0]), 64'h4433_2211);
    @(posedge clock); #1;
    oe[0] = 1'b0;
    @(posedge clock); #1;

    $display("txn lat3 abort/retry: ch0 addr 0x10");
    oe[0] = 1'b1; addr[12:0] = 13'h010; size[5:0] = 6'd32;
    @(negedge clock);
    chk("lat3 abort c1 rdy", 64'(m3_rdy[0]), 64'd0);
    @(posedge clock); #1;
    oe[0] = 1'b0;
    @(negedge clock);
    chk("lat3 dropped rdy", 64'(m3_rdy[0]), 64'd0);
    @(posedge clock); #1;
    oe[0] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      chk($sformatf("lat3 retry c%0d rdy", k), 64'(m3_rdy[0]), 64'(k == 3));
      if (k == 3) chk("lat3 retry data", 64'(m3_rdata[31:0]), 64'h4433_2211);
      @(posedge clock); #1;
    end
    oe[0] = 1'b0;
    @(posedge clock); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
